// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_HOLD,
    ST_DONE,
    ST_FAULT
  } fetch_state_e;

  localparam logic [31:0] DEFAULT_NOP = 32'h0000_0013;  // ADDI x0,x0,0

  localparam logic [1:0] FC_NONE     = 2'd0;
  localparam logic [1:0] FC_MISALIGN = 2'd1;
  localparam logic [1:0] FC_TIMEOUT  = 2'd2;

endpackage

// File: rtl/fetch_watchdog.sv
// Memory-response watchdog: counts enabled cycles and flags the last allowed one.
module fetch_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic srst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] count_reg;

  // Count holds the number of completed wait cycles, so the compare fires
  // during the TIMEOUT_CYCLES-th cycle and the FSM can still honour an ack then.
  always_ff @(posedge clk) begin
    if (srst || clear) begin
      count_reg <= 8'd0;
    end else if (enable && !expired) begin
      count_reg <= count_reg + 8'd1;
    end
  end

  assign expired = enable && (count_reg == LAST_COUNT);

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: reads pc_val, performs one memory word read per
// instruction and hands the result to the decoder, advancing the PC via inc.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter logic [31:0] NOP_INSTR      = DEFAULT_NOP
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] pc_val,
  input  logic        stall,
  input  logic        flush,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        mem_read,
  output logic [31:0] mem_addr,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic        inc,
  output logic        Disable,
  output logic        fault,
  output logic [1:0]  fault_code
);

  fetch_state_e state_reg;
  logic        mem_read_reg;
  logic [31:0] mem_addr_reg;
  logic [31:0] instr_reg;
  logic        instr_valid_reg;
  logic        inc_reg;
  logic        disable_reg;
  logic        fault_reg;
  logic [1:0]  fault_code_reg;
  logic        discard_reg;
  logic        wd_expired;

  fetch_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .srst   (clr),
    .clear  (state_reg == ST_IDLE),
    .enable (state_reg == ST_WAIT),
    .expired(wd_expired)
  );

  always_ff @(posedge clk) begin
    if (clr) begin
      state_reg       <= ST_IDLE;
      mem_read_reg    <= 1'b0;
      mem_addr_reg    <= 32'd0;
      instr_reg       <= NOP_INSTR;
      instr_valid_reg <= 1'b0;
      inc_reg         <= 1'b0;
      disable_reg     <= 1'b1;
      fault_reg       <= 1'b0;
      fault_code_reg  <= FC_NONE;
      discard_reg     <= 1'b0;
    end else begin
      inc_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          // A redirect makes pc_val stale; sample it again next cycle.
          if (flush) begin
            instr_reg       <= NOP_INSTR;
            instr_valid_reg <= 1'b0;
          end else if (pc_val[1:0] != 2'b00) begin
            state_reg      <= ST_FAULT;
            fault_reg      <= 1'b1;
            fault_code_reg <= FC_MISALIGN;
          end else begin
            mem_addr_reg <= pc_val;
            mem_read_reg <= 1'b1;
            state_reg    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (mem_ack) begin
            mem_read_reg <= 1'b0;
            discard_reg  <= 1'b0;
            if (flush || discard_reg) begin
              state_reg <= ST_IDLE;
              if (flush) begin
                instr_reg <= NOP_INSTR;
              end
            end else begin
              instr_reg       <= mem_rdata;
              instr_valid_reg <= 1'b1;
              if (stall) begin
                state_reg <= ST_HOLD;
              end else begin
                state_reg   <= ST_DONE;
                inc_reg     <= 1'b1;
                disable_reg <= 1'b0;
              end
            end
          end else if (wd_expired) begin
            state_reg      <= ST_FAULT;
            mem_read_reg   <= 1'b0;
            fault_reg      <= 1'b1;
            fault_code_reg <= FC_TIMEOUT;
          end else if (flush) begin
            // The bus transaction must complete; remember to drop its data.
            discard_reg <= 1'b1;
            instr_reg   <= NOP_INSTR;
          end
        end
        ST_HOLD: begin
          if (flush) begin
            state_reg       <= ST_IDLE;
            instr_reg       <= NOP_INSTR;
            instr_valid_reg <= 1'b0;
          end else if (!stall) begin
            state_reg   <= ST_DONE;
            inc_reg     <= 1'b1;
            disable_reg <= 1'b0;
          end
        end
        ST_DONE: begin
          state_reg       <= ST_IDLE;
          instr_valid_reg <= 1'b0;
          disable_reg     <= 1'b1;
          if (flush) begin
            instr_reg <= NOP_INSTR;
          end
        end
        ST_FAULT: begin
          state_reg <= ST_FAULT;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign mem_read    = mem_read_reg;
  assign mem_addr    = mem_addr_reg;
  assign instr       = instr_reg;
  assign instr_valid = instr_valid_reg;
  // A redirect arriving during DONE must not let the PC advance past it.
  assign inc         = inc_reg && !flush;
  assign Disable     = disable_reg;
  assign fault       = fault_reg;
  assign fault_code  = fault_code_reg;

endmodule
